// File: rtl/i2c_arbiter_pkg.sv
// i2c_arbiter_pkg
//   Shared definitions for the I2C requester arbiter: FSM state encoding,
//   transaction field width and the default retry / timeout limits.
package i2c_arbiter_pkg;

   localparam int unsigned FIELD_W         = 8;
   localparam int unsigned DEF_MAX_RETRY   = 3;
   localparam int unsigned DEF_TIMEOUT_CYC = 200000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/i2c_arbiter_rr_select.sv
// rr_select
//   Combinational round-robin picker. Returns the first set request at or
//   above ptr, wrapping modulo N.
//   req  : request vector
//   ptr  : search start index
//   gnt  : one-hot selection (zero when nothing requested)
//   idx  : binary index of the selection
//   any  : at least one request present
module rr_select #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Outer loop walks offsets from ptr so the nearest request wins; the inner
   // loop matches the wrapped position to a constant bit index.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned k = 0; k < N; k++) begin
            if (!any && req[k] && (((32'(ptr) + i) % N) == k)) begin
               any    = 1'b1;
               gnt[k] = 1'b1;
               idx    = IW'(k);
            end
         end
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one I2C master between N_REQ requesters with round-robin fairness,
//   bounded retries on master resend and a per-transaction timeout.
//   req_i / addr_i / reg_i / wdata_i : per-requester request and fields
//   gnt_o, done_o, err_o, rdata_o     : per-requester grant / completion
//   m_start_o, m_addr_o, m_reg_o, m_wdata_o : command to the I2C master
//   m_done_i, m_resend_i, m_rdata_i   : status from the I2C master
module i2c_arbiter
   import i2c_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_i,
   input  logic [FIELD_W*N_REQ-1:0]   addr_i,
   input  logic [FIELD_W*N_REQ-1:0]   reg_i,
   input  logic [FIELD_W*N_REQ-1:0]   wdata_i,
   output logic [N_REQ-1:0]           gnt_o,
   output logic [N_REQ-1:0]           done_o,
   output logic                       err_o,
   output logic [FIELD_W-1:0]         rdata_o,
   output logic                       m_start_o,
   output logic [FIELD_W-1:0]         m_addr_o,
   output logic [FIELD_W-1:0]         m_reg_o,
   output logic [FIELD_W-1:0]         m_wdata_o,
   input  logic                       m_done_i,
   input  logic                       m_resend_i,
   input  logic [FIELD_W-1:0]         m_rdata_i
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned RW = $clog2(MAX_RETRY + 2);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   state_t             state;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      g_idx;
   logic [RW-1:0]      retry_cnt;
   logic [TW-1:0]      tcnt;

   logic [N_REQ-1:0]   sel_gnt;
   logic [IW-1:0]      sel_idx;
   logic               sel_any;
   logic [FIELD_W-1:0] sel_addr;
   logic [FIELD_W-1:0] sel_reg;
   logic [FIELD_W-1:0] sel_wdata;

   rr_select #(.N(N_REQ)) u_rr_select (
      .req (req_i),
      .ptr (rr_ptr),
      .gnt (sel_gnt),
      .idx (sel_idx),
      .any (sel_any)
   );

   always_comb begin
      sel_addr  = '0;
      sel_reg   = '0;
      sel_wdata = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (sel_gnt[k]) begin
            sel_addr  = addr_i[k*FIELD_W +: FIELD_W];
            sel_reg   = reg_i[k*FIELD_W +: FIELD_W];
            sel_wdata = wdata_i[k*FIELD_W +: FIELD_W];
         end
      end
   end

   // done_o / err_o are loaded on the edge entering DONE so they are high for
   // exactly the DONE cycle; m_start_o is loaded on the edge leaving ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         g_idx     <= '0;
         retry_cnt <= '0;
         tcnt      <= '0;
         gnt_o     <= '0;
         done_o    <= '0;
         err_o     <= 1'b0;
         rdata_o   <= '0;
         m_start_o <= 1'b0;
         m_addr_o  <= '0;
         m_reg_o   <= '0;
         m_wdata_o <= '0;
      end else begin
         m_start_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (sel_any) begin
                  m_addr_o  <= sel_addr;
                  m_reg_o   <= sel_reg;
                  m_wdata_o <= sel_wdata;
                  gnt_o     <= sel_gnt;
                  g_idx     <= sel_idx;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               m_start_o <= 1'b1;
               tcnt      <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (m_resend_i) begin
                  if (retry_cnt < RW'(MAX_RETRY)) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     state     <= S_ISSUE;
                  end else begin
                     err_o  <= 1'b1;
                     done_o <= gnt_o;
                     state  <= S_DONE;
                  end
               end else if (m_done_i) begin
                  rdata_o <= m_rdata_i;
                  err_o   <= 1'b0;
                  done_o  <= gnt_o;
                  state   <= S_DONE;
               end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                  err_o  <= 1'b1;
                  done_o <= gnt_o;
                  state  <= S_DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            S_DONE: begin
               done_o    <= '0;
               err_o     <= 1'b0;
               gnt_o     <= '0;
               retry_cnt <= '0;
               rr_ptr    <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter
//   Directed, table-driven bench for i2c_arbiter (N_REQ=4, MAX_RETRY=3,
//   TIMEOUT_CYC=16) with hand sequences for resend/done collision, ignored
//   master pulses outside WAIT and reset during WAIT.
module tb_i2c_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_i;
   logic [8*N-1:0] addr_i, reg_i, wdata_i;
   logic [N-1:0]  gnt_o, done_o;
   logic          err_o;
   logic [7:0]    rdata_o;
   logic          m_start_o;
   logic [7:0]    m_addr_o, m_reg_o, m_wdata_o;
   logic          m_done_i, m_resend_i;
   logic [7:0]    m_rdata_i;

   int checks = 0;
   int errors = 0;

   i2c_arbiter #(.N_REQ(N), .MAX_RETRY(3), .TIMEOUT_CYC(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .addr_i     (addr_i),
      .reg_i      (reg_i),
      .wdata_i    (wdata_i),
      .gnt_o      (gnt_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .rdata_o    (rdata_o),
      .m_start_o  (m_start_o),
      .m_addr_o   (m_addr_o),
      .m_reg_o    (m_reg_o),
      .m_wdata_o  (m_wdata_o),
      .m_done_i   (m_done_i),
      .m_resend_i (m_resend_i),
      .m_rdata_i  (m_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      int          n_resend;
      bit          silent;
      logic [7:0]  rdata;
      logic [3:0]  exp_gnt;
      int          slot;
      bit          exp_err;
      int          exp_starts;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] slot_fields(input int k);
      logic [7:0] a, r, w;
      a = 8'h4F + 8'(k * 16);
      r = 8'h36 + 8'(k);
      w = 8'hA0 + 8'(k);
      return {a, r, w};
   endfunction

   task automatic set_fields();
      logic [23:0] f;
      for (int k = 0; k < N; k++) begin
         f = slot_fields(k);
         addr_i[k*8 +: 8]  = f[23:16];
         reg_i[k*8 +: 8]   = f[15:8];
         wdata_i[k*8 +: 8] = f[7:0];
      end
   endtask

   task automatic run_vec(input vec_t v, input bit first);
      int  starts, resp_left, cd, cs;
      bit  got;
      starts = 0; resp_left = v.n_resend; cd = 0; cs = 0; got = 1'b0;
      req_i = v.req;
      set_fields();
      for (int cyc = 0; cyc < 300 && !got; cyc++) begin
         @(negedge clk);
         m_done_i = 1'b0;
         m_resend_i = 1'b0;
         if (cyc == 0 && !first) chk("idle_gap", 64'({gnt_o, done_o}), 64'(0));
         if (done_o != '0) begin
            got = 1'b1;
            chk("done", 64'(done_o), 64'(v.exp_gnt));
            chk("gnt_at_done", 64'(gnt_o), 64'(v.exp_gnt));
            chk("err", 64'(err_o), 64'(v.exp_err));
            if (!v.exp_err) chk("rdata", 64'(rdata_o), 64'(v.rdata));
            chk("starts", 64'(starts), 64'(v.exp_starts));
            if (v.silent) chk("timeout_delay", 64'(cyc - cs), 64'(TO));
         end else if (m_start_o) begin
            if (starts == 0) chk("start_latency", 64'(cyc), first ? 64'(1) : 64'(2));
            starts++;
            cs = cyc;
            cd = 3;
            chk("gnt_at_start", 64'(gnt_o), 64'(v.exp_gnt));
            chk("m_fields", 64'({m_addr_o, m_reg_o, m_wdata_o}), 64'(slot_fields(v.slot)));
            // Corrupt the requester-side fields; later retries must not see this.
            addr_i = '1; reg_i = '1; wdata_i = '1;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0 && !v.silent) begin
               if (resp_left > 0) begin
                  m_resend_i = 1'b1;
                  resp_left--;
               end else begin
                  m_done_i  = 1'b1;
                  m_rdata_i = v.rdata;
               end
            end
         end
      end
      chk("done_seen", 64'(got), 64'(1));
   endtask

   task automatic pulse(input logic d, input logic r, input logic [7:0] data);
      @(negedge clk);
      m_done_i   = d;
      m_resend_i = r;
      m_rdata_i  = data;
   endtask

   task automatic wait_start(input string name, output bit saw_done);
      bit seen;
      seen = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         m_done_i = 1'b0;
         m_resend_i = 1'b0;
         if (done_o != '0) saw_done = 1'b1;
         if (m_start_o) seen = 1'b1;
      end
      chk(name, 64'(seen), 64'(1));
   endtask

   task automatic wait_done(input string name, input logic [3:0] eg, input logic eerr,
                            input logic [7:0] ed);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         m_done_i = 1'b0;
         m_resend_i = 1'b0;
         if (done_o != '0) begin
            seen = 1'b1;
            chk({name, "_done"}, 64'(done_o), 64'(eg));
            chk({name, "_err"}, 64'(err_o), 64'(eerr));
            chk({name, "_rdata"}, 64'(rdata_o), 64'(ed));
         end
      end
      chk({name, "_seen"}, 64'(seen), 64'(1));
   endtask

   initial begin
      bit         sd;
      logic [9:0] acc;

      //         req     rs sil rdata  gnt     slot err starts
      vecs[0] = '{4'b1011, 0, 0, 8'h11, 4'b0001, 0, 0, 1};
      vecs[1] = '{4'b1011, 0, 0, 8'h22, 4'b0010, 1, 0, 1};
      vecs[2] = '{4'b1011, 0, 0, 8'h33, 4'b1000, 3, 0, 1};
      vecs[3] = '{4'b1011, 0, 0, 8'h44, 4'b0001, 0, 0, 1};
      vecs[4] = '{4'b0001, 0, 0, 8'hA5, 4'b0001, 0, 0, 1};
      vecs[5] = '{4'b0100, 2, 0, 8'h3C, 4'b0100, 2, 0, 3};
      vecs[6] = '{4'b0100, 4, 0, 8'h00, 4'b0100, 2, 1, 4};
      vecs[7] = '{4'b1000, 0, 1, 8'h00, 4'b1000, 3, 1, 1};
      vecs[8] = '{4'b0010, 0, 0, 8'h77, 4'b0010, 1, 0, 1};

      rst = 1'b1;
      req_i = '0;
      m_done_i = 1'b0;
      m_resend_i = 1'b0;
      m_rdata_i = '0;
      set_fields();
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({gnt_o, done_o, err_o, m_start_o, rdata_o,
                                m_addr_o, m_reg_o, m_wdata_o}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i == 0);

      // Master pulses while idle must be ignored.
      req_i = '0;
      pulse(1'b1, 1'b1, 8'hEE);
      acc = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         m_done_i = 1'b0;
         m_resend_i = 1'b0;
         acc = acc | {gnt_o, done_o, m_start_o, err_o};
      end
      chk("idle_ignore", 64'(acc), 64'(0));

      // Simultaneous done and resend counts as a resend (rr_ptr is 2 here).
      req_i = 4'b0001;
      set_fields();
      wait_start("coll_first_start", sd);
      chk("coll_gnt", 64'(gnt_o), 64'(4'b0001));
      pulse(1'b1, 1'b1, 8'h99);
      wait_start("coll_restart", sd);
      chk("coll_no_done", 64'(sd), 64'(0));
      pulse(1'b1, 1'b0, 8'h5A);
      wait_done("coll", 4'b0001, 1'b0, 8'h5A);

      // Reset in WAIT: rr_ptr is 1, so port 3 wins before reset, port 0 after.
      req_i = 4'b1001;
      set_fields();
      wait_start("rst_start", sd);
      chk("rst_pre_gnt", 64'(gnt_o), 64'(4'b1000));
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_mid_outputs", 64'({gnt_o, done_o, err_o, m_start_o, rdata_o,
                                     m_addr_o, m_reg_o, m_wdata_o}), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_regrant", 64'(gnt_o), 64'(4'b0001));
      wait_start("rst_post_start", sd);
      chk("rst_post_addr", 64'(m_addr_o), 64'(8'h4F));
      pulse(1'b1, 1'b0, 8'hC3);
      wait_done("rst_post", 4'b0001, 1'b0, 8'hC3);
      req_i = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one I2C master.
REQ-002 Parameter MAX_RETRY, default 3, number of re-issues allowed after the master raises resend.
REQ-003 Parameter TIMEOUT_CYC, default 200000, clk cycles allowed in WAIT before abort.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  N_REQ  per-requester request level, held until that requester's done_o pulse.
REQ-007 addr_i  in  8*N_REQ  per-requester 8-bit device address byte (LSB 1 = read, 0 = write); slot k = bits [8k+7:8k].
REQ-008 reg_i  in  8*N_REQ  per-requester register address, same packing.
REQ-009 wdata_i  in  8*N_REQ  per-requester write data, same packing.
REQ-010 gnt_o  out  N_REQ  one-hot grant, high from latch until done cycle inclusive.
REQ-011 done_o  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-012 err_o  out  1  valid with done_o; 1 = retries exhausted or timeout.
REQ-013 rdata_o  out  8  read byte, valid with done_o, held until next done.
REQ-014 m_start_o  out  1  one-cycle start pulse to the I2C master.
REQ-015 m_addr_o, m_reg_o, m_wdata_o  out  8 each  latched transaction fields, stable from latch until DONE.
REQ-016 m_done_i  in  1  one-cycle master completion pulse.
REQ-017 m_resend_i  in  1  one-cycle master NACK / retry-request pulse.
REQ-018 m_rdata_i  in  8  master read data, valid with m_done_i.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, DONE; reset state IDLE.
REQ-020 IDLE: if any req_i bit set, select first set bit at or above rr_ptr (wrapping modulo N_REQ), latch its fields into m_*_o, set gnt_o one-hot, go ISSUE next cycle.
REQ-021 ISSUE: m_start_o = 1 for exactly this cycle, clear timeout counter, go WAIT.
REQ-022 WAIT, m_resend_i = 1: if retry_cnt < MAX_RETRY, increment retry_cnt, go ISSUE; else set err, go DONE.
REQ-023 WAIT, m_done_i = 1 and m_resend_i = 0: latch m_rdata_i into rdata_o, clear err, go DONE.
REQ-024 m_resend_i and m_done_i in the same cycle: resend wins.
REQ-025 WAIT: timeout counter increments every cycle; on reaching TIMEOUT_CYC-1 without m_done_i, set err, go DONE.
REQ-026 DONE: done_o[g] = 1 for one cycle, err_o driven, gnt_o cleared on exit, rr_ptr = (g+1) mod N_REQ, retry_cnt = 0, go IDLE.
REQ-027 Latency: req_i sampled high in IDLE at edge k -> gnt_o high after edge k, m_start_o high after edge k+1.
REQ-028 Deasserting req_i while granted does not abort; the transaction completes and done_o still pulses.
REQ-029 m_done_i / m_resend_i outside WAIT are ignored.
REQ-030 Changes to addr_i/reg_i/wdata_i after latch do not affect the in-flight transaction, including retries.
REQ-031 Fairness: a continuously requesting port waits at most N_REQ-1 transactions.

Reset
REQ-032 rst asserted (any time, incl. mid-transaction): state IDLE, gnt_o, done_o, err_o, m_start_o = 0; rdata_o, m_addr_o, m_reg_o, m_wdata_o = 8'h00; rr_ptr, retry_cnt, timeout counter = 0.
REQ-033 After rst release, first grant occurs no earlier than the first rising edge with rst low.

Structure
REQ-034 Shared package holds the FSM state encoding, the 8-bit field width constant, and default MAX_RETRY / TIMEOUT_CYC.
REQ-035 One sub-module, rr_select: combinational round-robin picker (req vector, pointer -> one-hot grant, index, any).

Verification
REQ-036 Single request: req_i=4'b0001, addr 8'h4F, reg 8'h36; master m_done_i with m_rdata_i=8'hA5 -> m_start_o once, m_addr_o=8'h4F, done_o=4'b0001, rdata_o=8'hA5, err_o=0.
REQ-037 Contention: req_i=4'b1011 held, each transaction completed -> grant order 0,1,3,0; exactly one m_start_o per transaction.
REQ-038 Retry: two m_resend_i pulses then m_done_i -> three m_start_o pulses, done_o with err_o=0; MAX_RETRY+1=4 resends -> four starts total, err_o=1.
REQ-039 Timeout: TIMEOUT_CYC=16, master silent -> done_o pulses exactly 16 cycles after m_start_o with err_o=1.
REQ-040 Simultaneous m_done_i and m_resend_i -> treated as resend (new m_start_o, no done_o).
REQ-041 rst pulse during WAIT -> all outputs zero next cycle; pending req_i re-granted from port 0 after release.
